// File: rtl/m_spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0): one MSB-first 8-bit frame per accepted start,
// framed by SS setup/hold times and followed by a fixed SS-high gap.
module m_spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned SS_SETUP = 2,
  parameter int unsigned SS_HOLD  = 2,
  parameter int unsigned GAP      = 4
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       MOSI,
  output logic       SS,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] HP_LAST    = 8'(CLK_DIV - 1);
  localparam logic [3:0] SETUP_LAST = 4'(SS_SETUP - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(SS_HOLD - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [7:0] hp_cnt_q, hp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] ph_cnt_q, ph_cnt_d;
  // Holds only the bits not yet on MOSI; MOSI itself is a separate flop.
  logic [6:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       ss_q, ss_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

  // Next-state and registered-output computation for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    hp_cnt_d   = hp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    ph_cnt_d   = ph_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETUP;
          tx_shift_d = tx_data[6:0];
          mosi_d     = tx_data[7];
          rx_shift_d = 8'h00;
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          ph_cnt_d   = 4'd0;
        end else begin
          mosi_d = 1'b0;
          ss_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (ph_cnt_q == SETUP_LAST) begin
          state_d   = ST_XFER;
          ph_cnt_d  = 4'd0;
          hp_cnt_d  = 8'd0;
          bit_cnt_d = 3'd0;
        end else begin
          ph_cnt_d = ph_cnt_q + 4'd1;
        end
      end
      ST_XFER: begin
        if (hp_cnt_q == HP_LAST) begin
          hp_cnt_d = 8'd0;
          if (!sclk_q) begin
            sclk_d     = 1'b1;
            rx_shift_d = {rx_shift_q[6:0], MISO};
          end else begin
            sclk_d = 1'b0;
            // The 8th falling edge leaves MOSI on bit 0 through the hold time.
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = ST_HOLD;
            end else begin
              bit_cnt_d  = bit_cnt_q + 3'd1;
              mosi_d     = tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
            end
          end
        end else begin
          hp_cnt_d = hp_cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (ph_cnt_q == HOLD_LAST) begin
          state_d   = ST_GAP;
          ph_cnt_d  = 4'd0;
          ss_d      = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (ph_cnt_q == GAP_LAST) begin
          state_d  = ST_IDLE;
          ph_cnt_d = 4'd0;
          busy_d   = 1'b0;
        end else begin
          ph_cnt_d = ph_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        ph_cnt_d = 4'd0;
        hp_cnt_d = 8'd0;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
        ss_d     = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset idles the bus with SS high.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state_q    <= ST_IDLE;
      hp_cnt_q   <= 8'd0;
      bit_cnt_q  <= 3'd0;
      ph_cnt_q   <= 4'd0;
      tx_shift_q <= 7'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ph_cnt_q   <= ph_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule
